// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared state encoding, field widths and checksum helper for the UART command sequencer
package uart_cmd_pkg;

    localparam int BYTE_W = 8;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam logic [BYTE_W-1:0] HEADER_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DHI   = 3'd2,
        ST_DLO   = 3'd3,
        ST_CSUM  = 3'd4,
        ST_WRITE = 3'd5
    } state_t;

    // Frame checksum: byte-wide sum of the three payload bytes, carries discarded.
    function automatic logic [BYTE_W-1:0] csum8(
        input logic [BYTE_W-1:0] a,
        input logic [BYTE_W-1:0] b,
        input logic [BYTE_W-1:0] c
    );
        csum8 = a + b + c;
    endfunction

endpackage

// File: rtl/uart_byte_strobe.sv
// rtl/uart_byte_strobe.sv - converts the receiver's per-byte toggle flag into a one-cycle byte strobe
module uart_byte_strobe (
    input  logic CLOCK,
    input  logic RESET_N,
    input  logic RX_TOGGLE,
    output logic STROBE
);

    logic toggle_q;
    logic toggle_d;

    // Registered copy simply follows the flag; the difference marks a new byte.
    always_comb begin
        toggle_d = RX_TOGGLE;
    end

    // Reset also tracks the flag so that releasing reset never looks like an edge.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            toggle_q <= RX_TOGGLE;
        end else begin
            toggle_q <= toggle_d;
        end
    end

    assign STROBE = RX_TOGGLE ^ toggle_q;

endmodule

// File: rtl/uart_cmd_sequencer.sv
// rtl/uart_cmd_sequencer.sv - decodes HEADER/ADDR/DHI/DLO/CSUM byte frames into acknowledged register writes
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 500000,
    parameter logic [BYTE_W-1:0] HEADER         = HEADER_DEFAULT
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic [BYTE_W-1:0] RX_DATA,
    input  logic              RX_TOGGLE,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [DATA_W-1:0] WR_DATA,
    output logic              WR_REQ,
    input  logic              WR_ACK,
    output logic              BUSY,
    output logic              ERR_CHECKSUM,
    output logic              ERR_TIMEOUT,
    output logic              ERR_OVERRUN,
    output logic [7:0]        FRAME_COUNT
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic strobe;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BYTE_W-1:0] addr_q, addr_d;
    logic [BYTE_W-1:0] dhi_q, dhi_d;
    logic [BYTE_W-1:0] dlo_q, dlo_d;
    logic [7:0]        frame_count_q, frame_count_d;
    logic              err_checksum_q, err_checksum_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_overrun_q, err_overrun_d;

    uart_byte_strobe u_strobe (
        .CLOCK     (CLOCK),
        .RESET_N   (RESET_N),
        .RX_TOGGLE (RX_TOGGLE),
        .STROBE    (strobe)
    );

    // Next-state, holding registers, inter-byte timer and error pulses.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        dhi_d          = dhi_q;
        dlo_d          = dlo_q;
        frame_count_d  = frame_count_q;
        err_checksum_d = 1'b0;
        err_timeout_d  = 1'b0;
        err_overrun_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (strobe && (RX_DATA == HEADER)) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR, ST_DHI, ST_DLO, ST_CSUM: begin
                // A byte arriving on the expiry cycle wins over the timeout.
                if (strobe) begin
                    cnt_d = '0;
                    case (state_q)
                        ST_ADDR: begin
                            addr_d  = RX_DATA;
                            state_d = ST_DHI;
                        end
                        ST_DHI: begin
                            dhi_d   = RX_DATA;
                            state_d = ST_DLO;
                        end
                        ST_DLO: begin
                            dlo_d   = RX_DATA;
                            state_d = ST_CSUM;
                        end
                        default: begin
                            if (RX_DATA == csum8(addr_q, dhi_q, dlo_q)) begin
                                state_d = ST_WRITE;
                            end else begin
                                err_checksum_d = 1'b1;
                                state_d        = ST_IDLE;
                            end
                        end
                    endcase
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d         = '0;
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WRITE: begin
                cnt_d = '0;
                if (strobe) begin
                    err_overrun_d = 1'b1;
                end
                if (WR_ACK) begin
                    frame_count_d = frame_count_q + 8'd1;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame or pending write.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            addr_q         <= '0;
            dhi_q          <= '0;
            dlo_q          <= '0;
            frame_count_q  <= '0;
            err_checksum_q <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overrun_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            dhi_q          <= dhi_d;
            dlo_q          <= dlo_d;
            frame_count_q  <= frame_count_d;
            err_checksum_q <= err_checksum_d;
            err_timeout_q  <= err_timeout_d;
            err_overrun_q  <= err_overrun_d;
        end
    end

    assign WR_ADDR      = addr_q;
    assign WR_DATA      = {dhi_q, dlo_q};
    assign WR_REQ       = (state_q == ST_WRITE);
    assign BUSY         = (state_q != ST_IDLE);
    assign ERR_CHECKSUM = err_checksum_q;
    assign ERR_TIMEOUT  = err_timeout_q;
    assign ERR_OVERRUN  = err_overrun_q;
    assign FRAME_COUNT  = frame_count_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb/tb_uart_cmd_sequencer.sv - directed self-checking bench for uart_cmd_sequencer
module tb_uart_cmd_sequencer;

    logic        CLOCK;
    logic        RESET_N;
    logic [7:0]  RX_DATA;
    logic        RX_TOGGLE;
    logic [7:0]  WR_ADDR;
    logic [15:0] WR_DATA;
    logic        WR_REQ;
    logic        WR_ACK;
    logic        BUSY;
    logic        ERR_CHECKSUM;
    logic        ERR_TIMEOUT;
    logic        ERR_OVERRUN;
    logic [7:0]  FRAME_COUNT;

    int checks = 0;
    int errors = 0;

    int n_ck  = 0;
    int n_to  = 0;
    int n_ov  = 0;
    int n_req = 0;

    uart_cmd_sequencer #(
        .TIMEOUT_CYCLES (100),
        .HEADER         (8'hA5)
    ) dut (
        .CLOCK        (CLOCK),
        .RESET_N      (RESET_N),
        .RX_DATA      (RX_DATA),
        .RX_TOGGLE    (RX_TOGGLE),
        .WR_ADDR      (WR_ADDR),
        .WR_DATA      (WR_DATA),
        .WR_REQ       (WR_REQ),
        .WR_ACK       (WR_ACK),
        .BUSY         (BUSY),
        .ERR_CHECKSUM (ERR_CHECKSUM),
        .ERR_TIMEOUT  (ERR_TIMEOUT),
        .ERR_OVERRUN  (ERR_OVERRUN),
        .FRAME_COUNT  (FRAME_COUNT)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Cycle-level tallies of pulses and request cycles, sampled mid-cycle.
    always @(negedge CLOCK) begin
        if (ERR_CHECKSUM === 1'b1) n_ck++;
        if (ERR_TIMEOUT === 1'b1)  n_to++;
        if (ERR_OVERRUN === 1'b1)  n_ov++;
        if (WR_REQ === 1'b1)       n_req++;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_DATA   = b;
        RX_TOGGLE = ~RX_TOGGLE;
        step();
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] h,
                              input logic [7:0] l, input logic [7:0] c);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(h);
        send_byte(l);
        send_byte(c);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r0;
        int c0;
        int t0;
        int o0;
        int e0;
        int n;
        logic [7:0] a;
        logic [7:0] h;
        logic [7:0] l;
        logic [7:0] c;

        RESET_N   = 1'b0;
        RX_DATA   = 8'h00;
        RX_TOGGLE = 1'b0;
        WR_ACK    = 1'b0;
        repeat (3) step();

        chk_eq("rst_req",   WR_REQ, 0);
        chk_eq("rst_addr",  WR_ADDR, 0);
        chk_eq("rst_data",  WR_DATA, 0);
        chk_eq("rst_busy",  BUSY, 0);
        chk_eq("rst_fc",    FRAME_COUNT, 0);
        chk_eq("rst_errs",  {ERR_CHECKSUM, ERR_TIMEOUT, ERR_OVERRUN}, 0);
        RESET_N = 1'b1;
        step();

        // Basic write, acknowledge after three request cycles.
        r0 = n_req;
        send_frame(8'h10, 8'h12, 8'h34, 8'h56);
        for (int i = 0; i < 3; i++) begin
            chk_eq("t1_req",  WR_REQ, 1);
            chk_eq("t1_addr", WR_ADDR, 32'h10);
            chk_eq("t1_data", WR_DATA, 32'h1234);
            if (i == 2) WR_ACK = 1'b1;
            step();
        end
        WR_ACK = 1'b0;
        chk_eq("t1_req_drop", WR_REQ, 0);
        chk_eq("t1_fc",       FRAME_COUNT, 1);
        chk_eq("t1_busy",     BUSY, 0);
        chk_eq("t1_req_cyc",  n_req - r0, 3);

        // Checksum mismatch.
        c0 = n_ck;
        r0 = n_req;
        send_frame(8'h10, 8'h12, 8'h34, 8'h57);
        chk_eq("t2_ck_hi",   ERR_CHECKSUM, 1);
        chk_eq("t2_busy",    BUSY, 0);
        step();
        chk_eq("t2_ck_lo",   ERR_CHECKSUM, 0);
        step();
        chk_eq("t2_ck_cnt",  n_ck - c0, 1);
        chk_eq("t2_no_req",  n_req - r0, 0);
        chk_eq("t2_fc",      FRAME_COUNT, 1);

        // Inter-byte timeout, then a clean frame.
        t0 = n_to;
        send_byte(8'hA5);
        send_byte(8'h10);
        n = 0;
        while (ERR_TIMEOUT !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk_eq("t3_to_lat",  n, 100);
        chk_eq("t3_busy",    BUSY, 0);
        step();
        chk_eq("t3_to_cnt",  n_to - t0, 1);
        send_frame(8'h01, 8'h00, 8'h00, 8'h01);
        chk_eq("t3_req",     WR_REQ, 1);
        chk_eq("t3_addr",    WR_ADDR, 32'h01);
        chk_eq("t3_data",    WR_DATA, 32'h0000);
        WR_ACK = 1'b1;
        step();
        WR_ACK = 1'b0;
        chk_eq("t3_req_drop", WR_REQ, 0);
        chk_eq("t3_fc",      FRAME_COUNT, 2);

        // Overrun while a write is pending.
        o0 = n_ov;
        send_frame(8'h20, 8'hAB, 8'hCD, 8'h98);
        chk_eq("t4_req",     WR_REQ, 1);
        send_byte(8'h77);
        chk_eq("t4_ov_hi",   ERR_OVERRUN, 1);
        chk_eq("t4_req2",    WR_REQ, 1);
        chk_eq("t4_addr",    WR_ADDR, 32'h20);
        chk_eq("t4_data",    WR_DATA, 32'hABCD);
        step();
        chk_eq("t4_ov_lo",   ERR_OVERRUN, 0);
        chk_eq("t4_req3",    WR_REQ, 1);
        chk_eq("t4_data2",   WR_DATA, 32'hABCD);
        chk_eq("t4_ov_cnt",  n_ov - o0, 1);
        WR_ACK = 1'b1;
        step();
        WR_ACK = 1'b0;
        chk_eq("t4_req_drop", WR_REQ, 0);
        chk_eq("t4_fc",      FRAME_COUNT, 3);

        // Junk before header, ACK held high: completion in first WRITE cycle.
        e0 = n_ck + n_to + n_ov;
        r0 = n_req;
        WR_ACK = 1'b1;
        send_byte(8'h00);
        send_byte(8'hFF);
        chk_eq("t5_idle",    BUSY, 0);
        send_frame(8'h30, 8'h01, 8'h02, 8'h33);
        chk_eq("t5_req",     WR_REQ, 1);
        chk_eq("t5_addr",    WR_ADDR, 32'h30);
        chk_eq("t5_data",    WR_DATA, 32'h0102);
        step();
        chk_eq("t5_req_drop", WR_REQ, 0);
        chk_eq("t5_fc",      FRAME_COUNT, 4);
        chk_eq("t5_req_cyc", n_req - r0, 1);
        chk_eq("t5_no_err",  (n_ck + n_to + n_ov) - e0, 0);

        // Frame counter wrap; addresses sweep through the header value too.
        for (int i = 0; i < 252; i++) begin
            a = i[7:0];
            h = a ^ 8'h5A;
            l = ~a;
            c = a + h + l;
            send_frame(a, h, l, c);
            step();
            if (i == 250) chk_eq("t5_fc_ff", FRAME_COUNT, 32'hFF);
        end
        chk_eq("t5_fc_wrap",  FRAME_COUNT, 0);
        chk_eq("t5_wrap_err", (n_ck + n_to + n_ov) - e0, 0);
        chk_eq("t5_wrap_req", n_req - r0, 253);
        WR_ACK = 1'b0;

        // Reset in the middle of a frame with the toggle flag high.
        if (RX_TOGGLE == 1'b0) send_byte(8'h00);
        send_byte(8'hA5);
        send_byte(8'h40);
        chk_eq("t6_busy_pre", BUSY, 1);
        chk_eq("t6_tog",      RX_TOGGLE, 1);
        RX_DATA = 8'hA5;
        RESET_N = 1'b0;
        step();
        chk_eq("t6_rst_busy", BUSY, 0);
        chk_eq("t6_rst_req",  WR_REQ, 0);
        chk_eq("t6_rst_fc",   FRAME_COUNT, 0);
        chk_eq("t6_rst_addr", WR_ADDR, 0);
        chk_eq("t6_rst_data", WR_DATA, 0);
        chk_eq("t6_rst_errs", {ERR_CHECKSUM, ERR_TIMEOUT, ERR_OVERRUN}, 0);
        step();
        RESET_N = 1'b1;
        step();
        chk_eq("t6_rel_req",  WR_REQ, 0);
        chk_eq("t6_rel_busy", BUSY, 0);
        step();
        chk_eq("t6_rel_busy2", BUSY, 0);
        WR_ACK = 1'b1;
        send_frame(8'h55, 8'h66, 8'h77, 8'h32);
        chk_eq("t6_req",      WR_REQ, 1);
        chk_eq("t6_addr",     WR_ADDR, 32'h55);
        chk_eq("t6_data",     WR_DATA, 32'h6677);
        step();
        WR_ACK = 1'b0;
        chk_eq("t6_req_drop", WR_REQ, 0);
        chk_eq("t6_fc",       FRAME_COUNT, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_sequencer.md
UART_CMD_SEQUENCER -- requirements
Module: uart_cmd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 500000, meaning the maximum idle clocks allowed between bytes of one frame.
REQ-002 SHALL have parameter HEADER, default 8'hA5, meaning the frame start byte.
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 SHALL have port CLOCK  in  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port RESET_N  in  1  synchronous active-low reset.
REQ-006 SHALL have port RX_DATA  in  8  received byte from the UART receiver.
REQ-007 SHALL have port RX_TOGGLE  in  1  byte-available flag; it toggles once per received byte.
REQ-008 SHALL have port WR_ADDR  out  8  register-write address.
REQ-009 SHALL have port WR_DATA  out  16  register-write data.
REQ-010 SHALL have port WR_REQ  out  1  write request, held until acknowledged.
REQ-011 SHALL have port WR_ACK  in  1  write acknowledge from the register file.
REQ-012 SHALL have port BUSY  out  1  high in any state other than IDLE.
REQ-013 SHALL have port ERR_CHECKSUM  out  1  one-cycle pulse on a checksum mismatch.
REQ-014 SHALL have port ERR_TIMEOUT  out  1  one-cycle pulse on an inter-byte timeout.
REQ-015 SHALL have port ERR_OVERRUN  out  1  one-cycle pulse when a byte arrives during WRITE.
REQ-016 SHALL have port FRAME_COUNT  out  8  count of completed writes, wrapping modulo 256.

Function
REQ-017 SHALL detect a new byte in the cycle where RX_TOGGLE differs from its registered copy (byte strobe); every toggle edge is one byte, either polarity.
REQ-018 SHALL accept frames of the form HEADER, ADDR, DHI, DLO, CSUM; CSUM is (ADDR+DHI+DLO) mod 256.
REQ-019 SHALL implement the states IDLE -> ADDR -> DHI -> DLO -> CSUM -> WRITE -> IDLE, advancing one state per byte strobe, except WRITE, which exits on acknowledge.
REQ-020 SHALL in IDLE discard every byte other than HEADER silently, with no error pulse.
REQ-021 SHALL capture ADDR, DHI and DLO into holding registers; WR_DATA = {DHI, DLO}.
REQ-022 SHALL in CSUM, on a match, enter WRITE with WR_REQ high on the cycle after the CSUM strobe (latency 1 clock).
REQ-023 SHALL in CSUM, on a mismatch, pulse ERR_CHECKSUM for one cycle and return to IDLE without asserting WR_REQ.
REQ-024 SHALL in WRITE hold WR_REQ, WR_ADDR and WR_DATA stable until WR_ACK is sampled high; the request then completes.
REQ-025 SHALL on completion drop WR_REQ on the next cycle, increment FRAME_COUNT (FF -> 00 wraps), and enter IDLE.
REQ-026 SHALL accept WR_ACK held high continuously, with completion in the first WRITE cycle.
REQ-027 SHALL ignore WR_ACK outside WRITE.
REQ-028 SHALL on a byte strobe during WRITE pulse ERR_OVERRUN, drop the byte, and remain in WRITE.
REQ-029 SHALL clear the timeout counter on every byte strobe and on entry to ADDR.
REQ-030 SHALL increment the timeout counter each clock in ADDR through CSUM without a strobe.
REQ-031 SHALL when the timeout counter reaches TIMEOUT_CYCLES-1 pulse ERR_TIMEOUT and enter IDLE.
REQ-032 SHALL not count timeout in IDLE or WRITE.
REQ-033 SHALL give a byte strobe priority over a timeout that expires in the same cycle; the byte is processed and no error is raised.
REQ-034 SHALL after a checksum or timeout error require a fresh HEADER; a HEADER-valued byte in ADDR/DHI/DLO is treated as data.

Reset
REQ-035 SHALL on RESET_N low at a clock edge set state=IDLE, WR_REQ=0, WR_ADDR=0, WR_DATA=0, FRAME_COUNT=0, all ERR_*=0, BUSY=0, and the timeout counter to 0.
REQ-036 SHALL during reset load the RX_TOGGLE registered copy from RX_TOGGLE, so no spurious strobe occurs on reset release.
REQ-037 SHALL abort any frame or pending write on reset mid-operation, and SHALL NOT assert WR_REQ in the first cycle after reset.

Structure
REQ-038 SHALL place the state encoding, default HEADER value and frame field widths in shared package uart_cmd_pkg.
REQ-039 SHALL implement the toggle-to-strobe detector as sub-module uart_byte_strobe (ports CLOCK, RESET_N, RX_TOGGLE, STROBE).

Verification
REQ-040 SHALL cover: bytes A5 10 12 34 56, WR_ACK after 3 cycles -> WR_REQ with WR_ADDR=10 and WR_DATA=1234, held 3 cycles, then FRAME_COUNT=1.
REQ-041 SHALL cover: A5 10 12 34 57 -> ERR_CHECKSUM pulse of one cycle, no WR_REQ, BUSY=0 afterwards.
REQ-042 SHALL cover: A5 10 then silence, TIMEOUT_CYCLES=100 -> ERR_TIMEOUT 100 clocks after the 10 strobe; the following A5 01 00 00 01 completes normally.
REQ-043 SHALL cover: a valid frame with WR_ACK held low and one extra byte sent -> ERR_OVERRUN pulse, WR_REQ and its data unchanged; completion occurs when ACK is raised.
REQ-044 SHALL cover: leading bytes 00 FF then a valid frame -> no errors and one write; 256 valid frames -> FRAME_COUNT wraps to 00.
REQ-045 SHALL cover: RESET_N low during DHI with RX_TOGGLE=1 -> all outputs at reset values, no strobe on release, and the next frame decodes correctly.
